// File: rtl/div_error_monitor_pkg.sv
// Shared types and widths for the divider accuracy monitor.
package div_mon_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int QUOT_W     = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_SUM_W  = 20;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CMP
  } state_t;

  // |exact - approx| in 5-bit signed arithmetic, magnitude kept to 4 bits.
  function automatic logic [QUOT_W-1:0] qerrAbs(input logic [QUOT_W-1:0] exactQ,
                                                input logic [QUOT_W-1:0] approxQ);
    logic [QUOT_W:0] diff;
    diff = {1'b0, exactQ} - {1'b0, approxQ};
    return diff[QUOT_W] ? (~diff[QUOT_W-1:0] + QUOT_W'(1)) : diff[QUOT_W-1:0];
  endfunction

endpackage

// File: rtl/div_error_monitor_if.sv
// Operand/result bundle between the divider side and the accuracy monitor.
interface div_error_monitor_if;
  import div_mon_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] in_x;
  logic [DIVISOR_W-1:0]  in_y;
  logic [QUOT_W-1:0]     in_q;
  logic [QUOT_W-1:0]     in_r;

  logic                  res_valid;
  logic                  res_ovf;
  logic [QUOT_W-1:0]     res_exact_q;
  logic [QUOT_W-1:0]     res_exact_r;
  logic [QUOT_W-1:0]     res_qerr;

  modport master (
    output in_valid, in_x, in_y, in_q, in_r,
    input  in_ready, res_valid, res_ovf, res_exact_q, res_exact_r, res_qerr
  );

  modport slave (
    input  in_valid, in_x, in_y, in_q, in_r,
    output in_ready, res_valid, res_ovf, res_exact_q, res_exact_r, res_qerr
  );

endinterface

// File: rtl/div_error_monitor_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module restoring_step (
  input  logic [4:0] pr_in,
  input  logic       bit_in,
  input  logic [3:0] y,
  output logic [4:0] pr_out,
  output logic       q_bit
);

  logic [4:0] shifted;
  logic [5:0] trial;

  assign shifted = {pr_in[3:0], bit_in};
  assign trial   = {1'b0, shifted} - {2'b00, y};
  // A set pr_in[4] means the true shifted value exceeds any divisor.
  assign q_bit   = pr_in[4] | ~trial[5];
  assign pr_out  = q_bit ? trial[4:0] : shifted;

endmodule

// File: rtl/div_error_monitor.sv
// Recomputes each divider result exactly and accumulates saturating error statistics.
module div_error_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic                clk,
  input  logic                rst,
  div_error_monitor_if.slave  bus,
  input  logic                clear,
  output logic [CNT_W-1:0]    stat_samples,
  output logic [CNT_W-1:0]    stat_mismatch,
  output logic [CNT_W-1:0]    stat_ovf,
  output logic [SUM_W-1:0]    stat_err_sum,
  output logic [QUOT_W-1:0]   stat_err_max
);

  state_t             state_q;
  logic [3:0]         xLow_q;
  logic [3:0]         y_q;
  logic [QUOT_W-1:0]  inQ_q, inR_q, quot_q;
  logic [4:0]         pr_q;
  logic [1:0]         cnt_q;
  logic               ovf_q;
  logic               inReady_q, resValid_q, resOvf_q;
  logic [QUOT_W-1:0]  resQ_q, resR_q, resErr_q;
  logic [CNT_W-1:0]   samples_q, mismatch_q, ovfCnt_q;
  logic [SUM_W-1:0]   errSum_q;
  logic [QUOT_W-1:0]  errMax_q;

  logic [4:0]         stepPr;
  logic               stepQ;
  logic               accept, acceptOvf, mismatch;
  logic [QUOT_W-1:0]  qerr;
  logic [SUM_W:0]     sumExt;
  logic [CNT_W-1:0]   samples_d, mismatch_d, ovfCnt_d;
  logic [SUM_W-1:0]   errSum_d;

  restoring_step u_step (
    .pr_in  (pr_q),
    .bit_in (xLow_q[cnt_q]),
    .y      (y_q),
    .pr_out (stepPr),
    .q_bit  (stepQ)
  );

  assign accept    = bus.in_valid && inReady_q;
  assign acceptOvf = (bus.in_y == '0) || (bus.in_x[7:4] >= bus.in_y);

  assign qerr      = ovf_q ? '0 : qerrAbs(quot_q, inQ_q);
  assign mismatch  = !ovf_q && ((quot_q != inQ_q) || (pr_q[QUOT_W-1:0] != inR_q));

  assign sumExt     = {1'b0, errSum_q} + {{(SUM_W + 1 - QUOT_W){1'b0}}, qerr};
  assign errSum_d   = sumExt[SUM_W] ? '1 : sumExt[SUM_W-1:0];
  assign samples_d  = (samples_q  == '1) ? samples_q  : samples_q  + CNT_W'(1);
  assign mismatch_d = (mismatch_q == '1) ? mismatch_q : mismatch_q + CNT_W'(1);
  assign ovfCnt_d   = (ovfCnt_q   == '1) ? ovfCnt_q   : ovfCnt_q   + CNT_W'(1);

  // Clear is applied last so it overrides a statistics update in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      xLow_q     <= '0;
      y_q        <= '0;
      inQ_q      <= '0;
      inR_q      <= '0;
      quot_q     <= '0;
      pr_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      inReady_q  <= 1'b1;
      resValid_q <= 1'b0;
      resOvf_q   <= 1'b0;
      resQ_q     <= '0;
      resR_q     <= '0;
      resErr_q   <= '0;
      samples_q  <= '0;
      mismatch_q <= '0;
      ovfCnt_q   <= '0;
      errSum_q   <= '0;
      errMax_q   <= '0;
    end else begin
      resValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            xLow_q    <= bus.in_x[3:0];
            y_q       <= bus.in_y;
            inQ_q     <= bus.in_q;
            inR_q     <= bus.in_r;
            quot_q    <= '0;
            pr_q      <= {1'b0, bus.in_x[7:4]};
            cnt_q     <= 2'd3;
            ovf_q     <= acceptOvf;
            inReady_q <= 1'b0;
            state_q   <= acceptOvf ? CMP : CALC;
          end
        end
        CALC: begin
          pr_q          <= stepPr;
          quot_q[cnt_q] <= stepQ;
          cnt_q         <= cnt_q - 2'd1;
          if (cnt_q == 2'd0) state_q <= CMP;
        end
        CMP: begin
          resValid_q <= 1'b1;
          resOvf_q   <= ovf_q;
          resQ_q     <= ovf_q ? '0 : quot_q;
          resR_q     <= ovf_q ? '0 : pr_q[QUOT_W-1:0];
          resErr_q   <= qerr;
          if (ovf_q) ovfCnt_q  <= ovfCnt_d;
          else       samples_q <= samples_d;
          if (mismatch) mismatch_q <= mismatch_d;
          errSum_q   <= errSum_d;
          if (qerr > errMax_q) errMax_q <= qerr;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (clear) begin
        samples_q  <= '0;
        mismatch_q <= '0;
        ovfCnt_q   <= '0;
        errSum_q   <= '0;
        errMax_q   <= '0;
      end
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.res_valid   = resValid_q;
  assign bus.res_ovf     = resOvf_q;
  assign bus.res_exact_q = resQ_q;
  assign bus.res_exact_r = resR_q;
  assign bus.res_qerr    = resErr_q;

  assign stat_samples  = samples_q;
  assign stat_mismatch = mismatch_q;
  assign stat_ovf      = ovfCnt_q;
  assign stat_err_sum  = errSum_q;
  assign stat_err_max  = errMax_q;

endmodule

// File: tb/tb_div_error_monitor.sv
// Randomized scoreboard bench for div_error_monitor against an arithmetic reference model.
module tb_div_error_monitor;
  import div_mon_pkg::*;

  localparam int CNT_W = 16;
  localparam int SUM_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int SMAX  = (1 << SUM_W) - 1;

  typedef struct {
    int ovf, q, r, qerr;
    int samples, mismatch, ovfCnt, errSum, errMax;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [CNT_W-1:0]  stat_samples, stat_mismatch, stat_ovf;
  logic [SUM_W-1:0]  stat_err_sum;
  logic [QUOT_W-1:0] stat_err_max;

  div_error_monitor_if bus();

  div_error_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .clear         (clear),
    .stat_samples  (stat_samples),
    .stat_mismatch (stat_mismatch),
    .stat_ovf      (stat_ovf),
    .stat_err_sum  (stat_err_sum),
    .stat_err_max  (stat_err_max)
  );

  exp_t expQ[$];
  exp_t monE;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mSamples = 0, mMismatch = 0, mOvf = 0, mSum = 0, mMax = 0;

  initial begin
    #20;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int satAdd(input int a, input int b, input int lim);
    return (a + b > lim) ? lim : a + b;
  endfunction

  // Reference: plain integer division plus the statistics rules.
  function automatic void modelPush(input int x, input int y, input int q, input int r,
                                    input int acceptCyc, input bit clr);
    exp_t e;
    int eq, er, d;
    bit ovf;
    ovf = (y == 0);
    if (!ovf) ovf = (x / y) > 15;
    eq = ovf ? 0 : x / y;
    er = ovf ? 0 : x % y;
    d  = eq - q;
    if (d < 0) d = -d;
    e.ovf  = ovf;
    e.q    = eq;
    e.r    = er;
    e.qerr = ovf ? 0 : (d & 15);
    if (clr) begin
      mSamples = 0; mMismatch = 0; mOvf = 0; mSum = 0; mMax = 0;
    end else begin
      if (ovf) mOvf = satAdd(mOvf, 1, CMAX);
      else     mSamples = satAdd(mSamples, 1, CMAX);
      if (!ovf && (eq != q || er != r)) mMismatch = satAdd(mMismatch, 1, CMAX);
      mSum = satAdd(mSum, e.qerr, SMAX);
      if (e.qerr > mMax) mMax = e.qerr;
    end
    e.samples  = mSamples;
    e.mismatch = mMismatch;
    e.ovfCnt   = mOvf;
    e.errSum   = mSum;
    e.errMax   = mMax;
    e.cyc      = acceptCyc + (ovf ? 1 : 5);
    expQ.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_res_valid: got pulse, want none (cycle %0d)", cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("res_latency_cycle", cyc, monE.cyc);
        checkOutput("res_ovf", 32'(bus.res_ovf), monE.ovf);
        checkOutput("res_exact_q", 32'(bus.res_exact_q), monE.q);
        checkOutput("res_exact_r", 32'(bus.res_exact_r), monE.r);
        checkOutput("res_qerr", 32'(bus.res_qerr), monE.qerr);
        checkOutput("stat_samples", 32'(stat_samples), monE.samples);
        checkOutput("stat_mismatch", 32'(stat_mismatch), monE.mismatch);
        checkOutput("stat_ovf", 32'(stat_ovf), monE.ovfCnt);
        checkOutput("stat_err_sum", 32'(stat_err_sum), monE.errSum);
        checkOutput("stat_err_max", 32'(stat_err_max), monE.errMax);
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic applyStimulus(input int x, input int y, input int q, input int r, input bit clrAtCmp);
    int n;
    int acc;
    int lat;
    bus.in_x     = 8'(x);
    bus.in_y     = 4'(y);
    bus.in_q     = 4'(q);
    bus.in_r     = 4'(r);
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checkOutput("accept_timeout", 1, 0);
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    lat = (y == 0 || (x / y) > 15) ? 1 : 5;
    modelPush(x, y, q, r, acc, clrAtCmp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (clrAtCmp) begin
      while (cyc < acc + lat - 1) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", expQ.size(), 0);
  endtask

  task automatic checkStatsZero(input string tag);
    checkOutput({tag, "_samples"}, 32'(stat_samples), 0);
    checkOutput({tag, "_mismatch"}, 32'(stat_mismatch), 0);
    checkOutput({tag, "_ovf"}, 32'(stat_ovf), 0);
    checkOutput({tag, "_err_sum"}, 32'(stat_err_sum), 0);
    checkOutput({tag, "_err_max"}, 32'(stat_err_max), 0);
  endtask

  initial begin
    int x, y, q, r, accepts;
    rst          = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_q     = '0;
    bus.in_r     = '0;
    #2;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
    checkOutput("reset_res_valid", 32'(bus.res_valid), 0);
    checkStatsZero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(40, 13, 3, 1, 1'b0);
    applyStimulus(7, 3, 1, 4, 1'b0);
    applyStimulus(80, 4, 0, 0, 1'b0);
    applyStimulus(16, 0, 0, 0, 1'b0);
    drain();

    bus.in_x = 8'd8; bus.in_y = 4'd4; bus.in_q = 4'd2; bus.in_r = 4'd0;
    bus.in_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_ready === 1'b1) begin
        accepts++;
        modelPush(8, 4, 2, 0, cyc + 1, 1'b0);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checkOutput("held_valid_accepts", accepts, 2);
    drain();
    applyStimulus(8, 4, 2, 0, 1'b1);
    drain();
    checkStatsZero("clear_at_cmp");

    for (int i = 0; i < 40; i++) begin
      y = $urandom_range(0, 15);
      if (y != 0 && $urandom_range(0, 3) != 0) x = $urandom_range(0, 16 * y - 1);
      else x = $urandom_range(0, 255);
      if (y != 0 && $urandom_range(0, 1) == 1) begin
        q = (x / y) & 15;
        r = (x % y) & 15;
      end else begin
        q = $urandom_range(0, 15);
        r = $urandom_range(0, 15);
      end
      applyStimulus(x, y, q, r, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mSamples = 0; mMismatch = 0; mOvf = 0; mSum = 0; mMax = 0;
    checkStatsZero("idle_clear");
    for (int i = 0; i < 20; i++) applyStimulus(239, 15, 0, 14, 1'b0);
    drain();
    checkOutput("err_sum_saturated", 32'(stat_err_sum), SMAX);
    checkOutput("err_max_after_sat", 32'(stat_err_max), 15);
    checkOutput("mismatch_after_sat", 32'(stat_mismatch), 20);

    bus.in_x = 8'd100; bus.in_y = 4'd9; bus.in_q = 4'd11; bus.in_r = 4'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    mSamples = 0; mMismatch = 0; mOvf = 0; mSum = 0; mMax = 0;
    #1;
    checkOutput("midcalc_rst_in_ready", 32'(bus.in_ready), 1);
    checkOutput("midcalc_rst_res_valid", 32'(bus.res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkStatsZero("midcalc_rst");
    checkOutput("midcalc_rst_ready_after", 32'(bus.in_ready), 1);
    checkOutput("midcalc_rst_queue", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_error_monitor.md
# div_error_monitor

Sequential accuracy monitor placed directly downstream of the approximate restoring array divider (8-bit dividend, 4-bit divisor, 4-bit quotient/remainder). For each divider result it recomputes the exact quotient and remainder with an iterative 4-step restoring divider, then compares the pair against the approximate result. It keeps saturating error statistics, so each approximation mask setting can be characterised in simulation or on silicon.

## Interface
- CNT_W, 16, width of sample, mismatch and overflow counters
- SUM_W, 20, width of the accumulated quotient-error sum
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/result bundle valid
- in_ready  out  1  monitor can accept a bundle
- in_x  in  8  dividend fed to the divider
- in_y  in  4  divisor fed to the divider
- in_q  in  4  approximate quotient from the divider
- in_r  in  4  approximate remainder from the divider
- clear  in  1  synchronous clear of all statistics
- res_valid  out  1  one-cycle pulse, per-sample result valid
- res_ovf  out  1  sample was overflow/divide-by-zero
- res_exact_q  out  4  exact quotient
- res_exact_r  out  4  exact remainder
- res_qerr  out  4  absolute value of (exact_q − in_q)
- stat_samples  out  CNT_W  non-overflow samples compared
- stat_mismatch  out  CNT_W  samples where q or r differ
- stat_ovf  out  CNT_W  overflow samples
- stat_err_sum  out  SUM_W  running sum of res_qerr
- stat_err_max  out  4  maximum res_qerr seen

## Operation
- Reset is asynchronous and active-high: every output and register goes to 0, state goes to IDLE, and in_ready goes to 1.
- The FSM has three states: IDLE, CALC and CMP.
- **IDLE**
  - in_ready is 1.
  - An accept is in_valid && in_ready. On an accept, all inputs are latched.
  - Overflow is defined as in_y==0 or in_x[7:4] >= in_y.
  - On overflow, the next state is CMP. Otherwise the next state is CALC, with the partial remainder set to the 5-bit value {1'b0,in_x[7:4]} and the step counter set to 3.
- **CALC** (4 cycles, in_ready=0)
  - Each cycle: pr' = {pr[3:0], x[cnt]}, then t = pr' − {1'b0,y}.
  - If t is non-negative: q[cnt]=1 and pr=t. Otherwise: q[cnt]=0 and pr=pr'.
  - The counter decrements each cycle. After the cnt=0 step, the next state is CMP.
- **CMP** (1 cycle, in_ready=0)
  - res_* outputs are registered and res_valid=1 for the following cycle. The next state is IDLE.
  - Overflow sample: res_ovf=1, res_exact_q/r/qerr=0, stat_ovf+1.
  - Non-overflow sample: res_exact_q/r = computed values; stat_samples+1.
  - If (q≠in_q or r≠in_r), stat_mismatch+1.
  - stat_err_sum += qerr, and stat_err_max = max(stat_err_max, qerr).
- **Arithmetic rules**
  - All counters and the sum saturate at all-ones; they never wrap.
  - qerr is computed in 5-bit signed arithmetic, and its magnitude is truncated to 4 bits.
- **Boundary conditions**
  - in_valid during CALC/CMP is ignored. The upstream source holds the bundle until it is accepted.
  - clear is honoured in any state. When clear coincides with a CMP update, clear wins: statistics become 0 and the sample is not counted, but res_* still update and res_valid still pulses.
  - rst asserted mid-CALC aborts the operation: no res_valid and no stat change.

## Timing
- Accept happens at edge E0.
- Non-overflow sample: CALC covers E1–E4, CMP is at E5. res_valid, res_* and the stats are visible after E5 (latency 5 edges).
- Overflow sample: CMP is at E1, so the results are visible after E1.
- After E5 (or E1 for overflow), in_ready is 1 again in the same cycle that res_valid=1, so a back-to-back accept is possible there.
- Throughput is one sample per 6 cycles, or per 2 cycles for overflow samples.
- Statistics are registered and are never combinational from the inputs.

## Structure
- Package div_mon_pkg holds:
  - the state enum (IDLE, CALC, CMP)
  - localparams DIVIDEND_W=8, DIVISOR_W=4, QUOT_W=4
  - the default CNT_W/SUM_W values
- Sub-module restoring_step: combinational single iteration (pr_in[4:0], bit_in, y[3:0] → pr_out[4:0], q_bit). It is instanced once and reused across CALC cycles.

## Test plan
1. Reset check: assert rst with no clock → all stats 0, res_valid 0, in_ready 1, state IDLE.
2. x=40, y=13, q=3, r=1 → 5 edges after accept: res_valid=1, exact_q=3, exact_r=1, qerr=0, stat_samples=1, stat_mismatch=0.
3. x=7, y=3, q=1, r=4 → exact_q=2, exact_r=1, qerr=1, stat_mismatch=1, stat_err_sum=1, stat_err_max=1.
4. x=80, y=4, then x=16, y=0 → each gives res_ovf=1 one edge after accept, stat_ovf=2, stat_samples unchanged.
5. in_valid held high with x=8, y=4, q=2, r=0 for 12 cycles → exactly 2 accepts, both exact with mismatch 0. Then pulse clear in the CMP cycle of a third sample → all stats 0 while res_valid still pulses.
6. Preload stat_err_sum near saturation via repeated qerr=15 samples → the sum sticks at 2^SUM_W−1. Separately, assert rst during CALC → no res_valid, counters 0, in_ready 1.
